// File: rtl/scmp_op_fetch_if.sv
// Memory read handshake and opcode-to-decoder handshake between the fetch unit
// (master) and the memory/microcode sequencer side (slave).
interface scmp_op_fetch_if;
    logic        bus_rd;
    logic [15:0] bus_addr;
    logic        bus_ack;
    logic [7:0]  bus_din;
    logic [7:0]  op_out;
    logic [7:0]  disp_out;
    logic        two_byte;
    logic        op_valid;
    logic        op_ready;

    modport master (
        output bus_rd, bus_addr, op_out, disp_out, two_byte, op_valid,
        input  bus_ack, bus_din, op_ready
    );

    modport slave (
        input  bus_rd, bus_addr, op_out, disp_out, two_byte, op_valid,
        output bus_ack, bus_din, op_ready
    );
endinterface

// File: rtl/scmp_op_fetch.sv
// SC/MP opcode fetch: pre-increments PC within its page, reads opcode (and
// displacement for op[7]=1), then presents {op, disp} to the decoder.
module scmp_op_fetch #(
    parameter int          PAGE_BITS = 12,
    parameter logic [15:0] RESET_PC  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pc_load,
    input  logic [15:0] pc_in,
    output logic [15:0] pc_out,
    output logic        busy,
    scmp_op_fetch_if.master bus
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        FETCH_OP   = 2'd1,
        FETCH_DISP = 2'd2,
        PRESENT    = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] pc_q, pc_nxt;
    logic [15:0] addr_q, addr_nxt;
    logic        rd_q, rd_nxt;
    logic [7:0]  op_q, op_nxt;
    logic [7:0]  disp_q, disp_nxt;
    logic        two_q, two_nxt;
    logic        vld_q, vld_nxt;
    logic [15:0] pc_base;

    // Only the in-page field counts; the page bits never see a carry.
    function automatic logic [15:0] pc_inc(input logic [15:0] p);
        logic [15:0] r;
        r = p;
        r[PAGE_BITS-1:0] = p[PAGE_BITS-1:0] + 1'b1;
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            pc_q   <= RESET_PC;
            addr_q <= 16'h0000;
            rd_q   <= 1'b0;
            op_q   <= 8'h00;
            disp_q <= 8'h00;
            two_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            pc_q   <= pc_nxt;
            addr_q <= addr_nxt;
            rd_q   <= rd_nxt;
            op_q   <= op_nxt;
            disp_q <= disp_nxt;
            two_q  <= two_nxt;
            vld_q  <= vld_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        addr_nxt  = addr_q;
        rd_nxt    = rd_q;
        op_nxt    = op_q;
        disp_nxt  = disp_q;
        two_nxt   = two_q;
        vld_nxt   = vld_q;
        // A load in the same cycle as start is applied first, then incremented.
        pc_base   = pc_load ? pc_in : pc_q;

        case (state)
            IDLE: begin
                pc_nxt = pc_base;
                if (start) begin
                    pc_nxt    = pc_inc(pc_base);
                    addr_nxt  = pc_inc(pc_base);
                    rd_nxt    = 1'b1;
                    state_nxt = FETCH_OP;
                end
            end
            FETCH_OP: begin
                if (bus.bus_ack) begin
                    op_nxt  = bus.bus_din;
                    two_nxt = bus.bus_din[7];
                    if (bus.bus_din[7]) begin
                        pc_nxt    = pc_inc(pc_q);
                        addr_nxt  = pc_inc(pc_q);
                        state_nxt = FETCH_DISP;
                    end else begin
                        disp_nxt  = 8'h00;
                        rd_nxt    = 1'b0;
                        vld_nxt   = 1'b1;
                        state_nxt = PRESENT;
                    end
                end
            end
            FETCH_DISP: begin
                if (bus.bus_ack) begin
                    disp_nxt  = bus.bus_din;
                    rd_nxt    = 1'b0;
                    vld_nxt   = 1'b1;
                    state_nxt = PRESENT;
                end
            end
            PRESENT: begin
                if (bus.op_ready) begin
                    vld_nxt   = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign pc_out       = pc_q;
    assign busy         = (state != IDLE);
    assign bus.bus_rd   = rd_q;
    assign bus.bus_addr = addr_q;
    assign bus.op_out   = op_q;
    assign bus.disp_out = disp_q;
    assign bus.two_byte = two_q;
    assign bus.op_valid = vld_q;

endmodule

// File: tb/tb_scmp_op_fetch.sv
// Bench for scmp_op_fetch: directed scenarios plus randomized instructions
// checked against a transaction-level model of PC stepping and fetch results.
module tb_scmp_op_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        pc_load;
    logic [15:0] pc_in;
    logic [15:0] pc_out;
    logic        busy;

    scmp_op_fetch_if bus_if ();

    scmp_op_fetch #(
        .PAGE_BITS (12),
        .RESET_PC  (16'h0000)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .pc_load (pc_load),
        .pc_in   (pc_in),
        .pc_out  (pc_out),
        .busy    (busy),
        .bus     (bus_if)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [15:0] exp_pc;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Next PC within a 4K page: low 12 bits wrap, page bits untouched.
    function automatic logic [15:0] ref_inc(input logic [15:0] p);
        return (p & 16'hF000) | ((p + 16'd1) & 16'h0FFF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input bit do_load, input bit load_with_start,
                             input logic [15:0] load_val, input logic [7:0] op,
                             input logic [7:0] disp, input int d0, input int d1,
                             input int bp, input bit noise);
        logic [15:0] a0, a1;
        logic [7:0]  exp_disp;
        logic        two;
        int          lat;

        if (do_load && !load_with_start) begin
            pc_load = 1'b1;
            pc_in   = load_val;
            tick();
            pc_load = 1'b0;
            exp_pc  = load_val;
            chk("pc_load", pc_out, exp_pc);
            chk("busy_after_load", busy, 0);
        end
        if (do_load && load_with_start) begin
            pc_load = 1'b1;
            pc_in   = load_val;
            exp_pc  = load_val;
        end

        a0       = ref_inc(exp_pc);
        two      = op[7];
        a1       = two ? ref_inc(a0) : a0;
        exp_disp = two ? disp : 8'h00;

        start = 1'b1;
        tick();
        start   = 1'b0;
        pc_load = 1'b0;
        lat     = 1;
        chk("rd_op", bus_if.bus_rd, 1);
        chk("addr_op", bus_if.bus_addr, a0);
        chk("pc_op", pc_out, a0);
        chk("busy_op", busy, 1);

        repeat (d0) begin
            if (noise) begin
                start           = 1'($urandom_range(0, 1));
                pc_load         = 1'($urandom_range(0, 1));
                pc_in           = 16'($urandom);
                bus_if.op_ready = 1'($urandom_range(0, 1));
            end
            tick();
            lat++;
            chk("hold_op", {bus_if.bus_rd, bus_if.bus_addr, pc_out}, {1'b1, a0, a0});
            chk("vld_early_op", bus_if.op_valid, 0);
        end
        start           = 1'b0;
        pc_load         = 1'b0;
        bus_if.op_ready = 1'b0;
        bus_if.bus_ack  = 1'b1;
        bus_if.bus_din  = op;
        tick();
        lat++;
        bus_if.bus_ack = 1'b0;
        bus_if.bus_din = 8'($urandom);

        if (two) begin
            chk("rd_disp", bus_if.bus_rd, 1);
            chk("addr_disp", bus_if.bus_addr, a1);
            chk("pc_disp", pc_out, a1);
            chk("vld_early_disp", bus_if.op_valid, 0);
            repeat (d1) begin
                if (noise) begin
                    start           = 1'($urandom_range(0, 1));
                    bus_if.op_ready = 1'($urandom_range(0, 1));
                end
                tick();
                lat++;
                chk("hold_disp", {bus_if.bus_rd, bus_if.bus_addr}, {1'b1, a1});
                chk("vld_wait_disp", bus_if.op_valid, 0);
            end
            start           = 1'b0;
            bus_if.op_ready = 1'b0;
            bus_if.bus_ack  = 1'b1;
            bus_if.bus_din  = disp;
            tick();
            lat++;
            bus_if.bus_ack = 1'b0;
            bus_if.bus_din = 8'($urandom);
        end

        chk("vld", bus_if.op_valid, 1);
        chk("op", bus_if.op_out, op);
        chk("disp", bus_if.disp_out, exp_disp);
        chk("two_byte", bus_if.two_byte, two);
        chk("rd_off", bus_if.bus_rd, 0);
        chk("pc_present", pc_out, a1);
        chk("busy_present", busy, 1);
        if (d0 == 0 && (!two || d1 == 0))
            chk("latency", lat, two ? 3 : 2);
        exp_pc = a1;

        repeat (bp) begin
            bus_if.op_ready = 1'b0;
            if (noise) begin
                start          = 1'($urandom_range(0, 1));
                bus_if.bus_ack = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b1;
            end
            tick();
            chk("bp_hold", {bus_if.op_valid, bus_if.op_out, bus_if.disp_out, bus_if.two_byte},
                {1'b1, op, exp_disp, two});
            chk("bp_state", {busy, bus_if.bus_rd, pc_out}, {1'b1, 1'b0, exp_pc});
        end

        start           = 1'b0;
        bus_if.bus_ack  = 1'b0;
        bus_if.op_ready = 1'b1;
        tick();
        bus_if.op_ready = 1'b0;
        chk("vld_drop", bus_if.op_valid, 0);
        chk("busy_idle", busy, 0);
        chk("pc_idle", pc_out, exp_pc);

        if (noise) begin
            bus_if.bus_ack = 1'($urandom_range(0, 1));
            tick();
            bus_if.bus_ack = 1'b0;
            chk("idle_ack_ignored", {busy, bus_if.bus_rd, pc_out}, {1'b0, 1'b0, exp_pc});
        end
    endtask

    initial begin
        rst             = 1'b1;
        start           = 1'b0;
        pc_load         = 1'b0;
        pc_in           = 16'h0000;
        bus_if.bus_ack  = 1'b0;
        bus_if.bus_din  = 8'h00;
        bus_if.op_ready = 1'b0;
        tick();
        tick();
        chk("rst_rd", bus_if.bus_rd, 0);
        chk("rst_addr", bus_if.bus_addr, 16'h0000);
        chk("rst_outs", {bus_if.op_out, bus_if.disp_out, bus_if.two_byte, bus_if.op_valid}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pc", pc_out, 16'h0000);
        rst    = 1'b0;
        exp_pc = 16'h0000;

        run_instr(1'b0, 1'b0, 16'h0000, 8'h08, 8'h00, 0, 0, 0, 1'b0);
        run_instr(1'b1, 1'b0, 16'h2010, 8'hC4, 8'h55, 3, 3, 0, 1'b0);
        run_instr(1'b1, 1'b0, 16'h1FFE, 8'h90, 8'hAB, 0, 0, 0, 1'b0);
        chk("page_wrap_pc", pc_out, 16'h1000);
        run_instr(1'b0, 1'b0, 16'h0000, 8'h3F, 8'h00, 1, 0, 5, 1'b0);
        run_instr(1'b1, 1'b1, 16'h3000, 8'h08, 8'h00, 0, 0, 0, 1'b0);
        chk("load_and_start_pc", pc_out, 16'h3001);

        // Reset while waiting for the displacement byte.
        start = 1'b1;
        tick();
        start          = 1'b0;
        bus_if.bus_ack = 1'b1;
        bus_if.bus_din = 8'hC4;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("pre_rst_disp_addr", bus_if.bus_addr, 16'h3003);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst", {bus_if.bus_rd, bus_if.op_valid, busy}, 0);
        chk("mid_rst_pc", pc_out, 16'h0000);
        bus_if.bus_ack = 1'b1;
        bus_if.bus_din = 8'h77;
        tick();
        bus_if.bus_ack = 1'b0;
        chk("late_ack", {bus_if.bus_rd, bus_if.op_valid, busy}, 0);
        chk("late_ack_pc", pc_out, 16'h0000);
        exp_pc = 16'h0000;

        repeat (60) begin
            run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'($urandom),
                      8'($urandom), 8'($urandom), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
